rv_stage_sequencer: RTL and testbench

// - Multicycle control FSM for the rv_cpu datapath. It steps fetcher, decoder, exec/memaccess
//   and writeback through one instruction at a time.
// - Handshakes with instruction and data memory, and raises the commit strobe that updates
//   pc_reg and general_reg.
// - Traps on an illegal opcode or a memory timeout.

---
 rtl/rv_stage_sequencer_if.sv | 31 +++
 rtl/rv_stage_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_rv_stage_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_stage_sequencer_if.sv
// Handshake and strobe bundle between rv_stage_sequencer (master) and the rv_cpu datapath
// and memories (slave).
interface rv_stage_sequencer_if;
    logic       run;
    logic       illegal;
    logic       is_mem;
    logic       imem_req;
    logic       imem_ack;
    logic       dmem_req;
    logic       dmem_ack;
    logic       fetch_en;
    logic       decode_en;
    logic       exec_en;
    logic       wb_en;
    logic       commit;
    logic [2:0] state;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  run, illegal, is_mem, imem_ack, dmem_ack,
        output imem_req, dmem_req, fetch_en, decode_en, exec_en, wb_en, commit,
        output state, trap, trap_cause
    );

    modport slave (
        output run, illegal, is_mem, imem_ack, dmem_ack,
        input  imem_req, dmem_req, fetch_en, decode_en, exec_en, wb_en, commit,
        input  state, trap, trap_cause
    );
endinterface

// File: rtl/rv_stage_sequencer.sv
// Multicycle control FSM stepping fetch/decode/exec/mem/writeback for rv_cpu.
// Define RV_SEQ_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module rv_stage_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
`ifdef RV_SEQ_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic                   CLK,
    input  logic                   RST,
    rv_stage_sequencer_if.master   bus
`ifdef RV_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instret_cnt
`endif
);

    localparam int unsigned WaitW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             is_mem_q, is_mem_d;
    logic [1:0]       cause_q, cause_d;

    logic             timeout_hit;
    logic [WaitW-1:0] wait_inc;

    // Saturate so a disabled timeout never wraps the counter back to a trap value.
    assign wait_inc    = (wait_q == {WaitW{1'b1}}) ? wait_q : wait_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == WaitW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        is_mem_d = is_mem_q;
        cause_d  = cause_q;
        case (state_q)
            StIdle: begin
                if (bus.run) begin
                    state_d = StFetch;
                    wait_d  = '0;
                end
            end
            StFetch: begin
                if (bus.imem_ack) begin
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d = StTrap;
                    cause_d = 2'd2;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StDecode: begin
                if (bus.illegal) begin
                    state_d = StTrap;
                    cause_d = 2'd1;
                end else begin
                    state_d  = StExec;
                    is_mem_d = bus.is_mem;
                end
            end
            StExec: begin
                if (is_mem_q) begin
                    state_d = StMem;
                    wait_d  = '0;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (bus.dmem_ack) begin
                    state_d = StWb;
                end else if (timeout_hit) begin
                    state_d = StTrap;
                    cause_d = 2'd3;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StWb: begin
                if (bus.run) begin
                    state_d = StFetch;
                    wait_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            wait_q   <= '0;
            is_mem_q <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            is_mem_q <= is_mem_d;
            cause_q  <= cause_d;
        end
    end

    // Moore decode of the registered state; reset forces StIdle so every strobe drops at once.
    always_comb begin
        bus.imem_req   = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.decode_en  = 1'b0;
        bus.exec_en    = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.wb_en      = 1'b0;
        bus.commit     = 1'b0;
        bus.trap       = 1'b0;
        bus.state      = state_q;
        bus.trap_cause = cause_q;
        case (state_q)
            StFetch: begin
                bus.imem_req = 1'b1;
                bus.fetch_en = bus.imem_ack;
            end
            StDecode: bus.decode_en = 1'b1;
            StExec:   bus.exec_en   = 1'b1;
            StMem:    bus.dmem_req  = 1'b1;
            StWb: begin
                bus.wb_en  = 1'b1;
                bus.commit = 1'b1;
            end
            StTrap:   bus.trap      = 1'b1;
            default:  ;
        endcase
    end

`ifdef RV_SEQ_PERF_EN
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (state_q != StIdle && state_q != StTrap) begin
            cycle_d = cycle_q + 1'b1;
        end
        if (state_q == StWb) begin
            instret_d = instret_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_rv_stage_sequencer.sv
// Randomized and directed bench for rv_stage_sequencer against a stage-level reference model.
module tb_rv_stage_sequencer;

    localparam int T = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    rv_stage_sequencer_if bus();

`ifdef RV_SEQ_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    rv_stage_sequencer #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus)
`ifdef RV_SEQ_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: current stage number, cycles already waited in this stage, trap cause,
    // latched load/store flag, and the performance tallies.
    int m_stage, m_waited, m_cause, m_ldst, m_cyc, m_ret;
    int seen_commits, total_model_ret;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] act_outs();
        return {bus.imem_req, bus.fetch_en, bus.decode_en, bus.exec_en, bus.dmem_req,
                bus.wb_en, bus.commit, bus.trap, bus.trap_cause};
    endfunction

    function automatic logic [9:0] exp_outs(input int s, input int c, input logic ia);
        logic [1:0] cc;
        cc = c[1:0];
        return {s == 1, s == 1 && ia, s == 2, s == 3, s == 4, s == 5, s == 5, s == 6, cc};
    endfunction

    task automatic model_reset();
        m_stage  = 0;
        m_waited = 0;
        m_cause  = 0;
        m_ldst   = 0;
        m_cyc    = 0;
        m_ret    = 0;
    endtask

    // Called at posedge+1: drive inputs, check at negedge, advance model over the next edge.
    task automatic step(input logic r, input logic il, input logic im, input logic ia,
                        input logic da);
        int nxt;
        bus.run      = r;
        bus.illegal  = il;
        bus.is_mem   = im;
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        @(negedge CLK);
        check("state", {29'd0, bus.state}, m_stage);
        check("outs", {22'd0, act_outs()}, {22'd0, exp_outs(m_stage, m_cause, ia)});
`ifdef RV_SEQ_PERF_EN
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("instret_cnt", instret_cnt, m_ret);
`endif
        if (bus.commit) seen_commits++;
        @(posedge CLK);
        if (m_stage != 0 && m_stage != 6) m_cyc++;
        if (m_stage == 5) begin
            m_ret++;
            total_model_ret++;
        end
        nxt = m_stage;
        case (m_stage)
            0: nxt = r ? 1 : 0;
            1, 4: begin
                if ((m_stage == 1) ? ia : da) nxt = m_stage + 1 + (m_stage == 1 ? 0 : 0);
                else if (m_waited + 1 == T) begin
                    nxt     = 6;
                    m_cause = (m_stage == 1) ? 2 : 3;
                end else m_waited++;
                if (m_stage == 4 && da) nxt = 5;
            end
            2: begin
                if (il) begin
                    nxt     = 6;
                    m_cause = 1;
                end else begin
                    nxt    = 3;
                    m_ldst = im;
                end
            end
            3: nxt = m_ldst ? 4 : 5;
            5: nxt = r ? 1 : 0;
            default: nxt = 6;
        endcase
        if ((nxt == 1 || nxt == 4) && nxt != m_stage) m_waited = 0;
        m_stage = nxt;
        #1;
    endtask

    // Assert reset between edges and confirm everything drops before the next edge.
    task automatic do_reset();
        #3;
        RST = 1'b1;
        #1;
        check("rst_state", {29'd0, bus.state}, 32'd0);
        check("rst_outs", {22'd0, act_outs()}, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    int base;
    int p_ack;

    initial begin
        bus.run = 1'b0; bus.illegal = 1'b0; bus.is_mem = 1'b0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        seen_commits = 0;
        total_model_ret = 0;
        model_reset();
        @(posedge CLK);
        #1;
        do_reset();

        // Reset while a fetch request is outstanding.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("req_before_rst", {31'd0, bus.imem_req}, 32'd1);
        do_reset();

        // Zero-wait non-mem stream: one commit per 4 cycles.
        base = seen_commits;
        for (int i = 0; i < 13; i++) step(1, 0, 0, 1, 1);
        check("zero_wait_commits", seen_commits - base, 32'd3);
        do_reset();

        // Load/store with dmem_ack held off for 3 cycles; ack on the timeout cycle wins.
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 1);
        check("mem_to_wb", {29'd0, bus.state}, 32'd5);
        do_reset();

        // Illegal opcode traps and holds with no commit.
        base = seen_commits;
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        for (int i = 0; i < 20; i++) step(1, 0, 1, 1'($urandom), 1'($urandom));
        check("illegal_no_commit", seen_commits - base, 32'd0);
        check("illegal_cause", {30'd0, bus.trap_cause}, 32'd1);
        do_reset();

        // Fetch timeout after T cycles without ack.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < T; i++) step(1, 0, 0, 0, 0);
        check("ifetch_timeout", {27'd0, bus.state, bus.trap_cause}, {27'd0, 3'd6, 2'd2});
        do_reset();

        // Ack on the T-th fetch cycle still reaches decode.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < T - 1; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        check("late_ack_decode", {29'd0, bus.state}, 32'd2);
        do_reset();

        // run dropped during EXEC: one commit then idle.
        base = seen_commits;
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("run_drop_commits", seen_commits - base, 32'd1);
        check("run_drop_idle", {29'd0, bus.state}, 32'd0);
        do_reset();

`ifdef RV_SEQ_PERF_EN
        for (int i = 0; i < 41; i++) step(1, 0, 0, 1, 1);
        @(negedge CLK);
        check("perf_instret10", instret_cnt, 32'd10);
        check("perf_cycle40", cycle_cnt, 32'd40);
        do_reset();
`endif

        // Random episodes with varying memory responsiveness.
        for (int ep = 0; ep < 25; ep++) begin
            p_ack = $urandom_range(1, 4);
            for (int i = 0; i < 80; i++) begin
                step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, 1'($urandom),
                     $urandom_range(1, 4) <= p_ack, $urandom_range(1, 4) <= p_ack);
            end
            do_reset();
        end

        check("total_commits", seen_commits, total_model_ret);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
